// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that drains a FIFO: pops one byte whenever idle and
// the FIFO is non-empty, then shifts it out LSB first on a registered tx line.
`timescale 1ns/1ps
module uart_fifo_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_fifo_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] baud_cnt, baud_nx;
  logic [2:0]       bit_cnt, bit_nx;
  logic [7:0]       shift, shift_nx;
  logic             tx_nx, done_nx;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_MAX);
  assign tx_busy = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    baud_nx  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    done_nx  = 1'b0;
    fifo_pop = 1'b0;

    case (state)
      IDLE: begin
        baud_nx = '0;
        // Gated by rst so no pop can escape while the line is held in reset.
        fifo_pop = !fifo_empty && !rst;
        if (fifo_pop) begin
          shift_nx = fifo_rdata;
          bit_nx   = 3'd0;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_nx = shift >> 1;
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // tx is derived from the next state so the line register lines up with it.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      // NOTE: the shift register is reset as well; the in-flight byte is
      // dropped and must not leak into a later frame.
      shift    <= 8'h00;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
      tx_done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a behavioural FIFO feeds the DUT, a monitor decodes
// each frame and checks it against the bytes pushed into the FIFO, in order.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty, fifo_pop, tx, tx_busy, tx_done;
  logic [7:0] fifo_rdata;

  uart_fifo_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 16-deep FIFO model; also records every pushed byte as the expected stream.
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0, rp = 4'd0;
  logic [4:0] cnt = 5'd0;
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       ovr_en = 1'b0, ovr_empty = 1'b1;
  logic [7:0] ovr_data = 8'h00;
  logic [7:0] exp_q [$];

  always @(posedge clk) begin
    if (push_en) begin
      mem[wp] <= push_data;
      wp      <= wp + 4'd1;
      exp_q.push_back(push_data);
    end
    if (fifo_pop && cnt != 5'd0) rp <= rp + 4'd1;
    cnt <= cnt + 5'(push_en) - 5'(fifo_pop && cnt != 5'd0);
  end

  always_comb begin
    fifo_empty = ovr_en ? ovr_empty : (cnt == 5'd0);
    fifo_rdata = ovr_en ? ovr_data : mem[rp];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done = 0;
  always @(negedge clk) if (tx_done === 1'b1) n_done <= n_done + 1;

  // Monitor: starts a frame on each pop, checks every cycle of it.
  int         n_pops = 0;
  int         rd_idx = 0;
  int         idle_bad = 0;
  int         pop_cyc [$];
  logic [9:0] last_bits = '0;

  initial begin : monitor
    bit         chained, aborted, bad;
    logic [7:0] exp_b;
    logic [9:0] bits, samp;
    chained = 1'b0;
    forever begin
      if (!chained) @(negedge clk);
      if (rst || !fifo_pop) begin
        if (!chained && (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0)) idle_bad++;
        chained = 1'b0;
      end else begin
        chained = 1'b0;
        n_pops++;
        pop_cyc.push_back(cyc);
        check("pop_has_expected_byte", 32'(rd_idx < exp_q.size()), 32'd1);
        exp_b = (rd_idx < exp_q.size()) ? exp_q[rd_idx] : 8'h00;
        rd_idx++;
        bits    = {1'b1, exp_b, 1'b0};
        samp    = '0;
        bad     = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== bits[c/10] || tx_busy !== 1'b1 || tx_done !== 1'b0 || fifo_pop !== 1'b0)
            bad = 1'b1;
          if (c % 10 == 5) samp[c/10] = tx;
        end
        if (!aborted) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          check("frame_shape", 32'(bad), 32'd0);
          check("frame_byte", 32'(samp[8:1]), 32'(exp_b));
          check("stop_tx_busy_done", 32'({tx, tx_busy, tx_done}), 32'b101);
          last_bits = samp;
          chained   = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_en   = 1'b1;
    push_data = b;
    step(1);
    push_en   = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int k = 0;
    while (n_pops < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, 32'(n_pops >= target), 32'd1);
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, 32'(n_done >= target), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset with FIFO empty, then a long idle stretch.
    step(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    step(500);
    check("idle_no_pop", 32'(n_pops), 32'd0);
    check("idle_line_high", 32'(idle_bad), 32'd0);

    // Single byte 0xA5.
    push(8'hA5);
    wait_pops("a5_pop", 1, 20);
    wait_done("a5_done", 1, 200);
    step(3);
    check("a5_slot_bits", 32'(last_bits), 32'b1101001010);
    check("a5_one_pop", 32'(n_pops), 32'd1);
    check("a5_one_done", 32'(n_done), 32'd1);
    check("a5_fifo_empty", 32'(fifo_empty), 32'd1);

    // Three bytes queued together: back-to-back frames 101 cycles apart.
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_done("burst_done", 4, 500);
    step(3);
    check("burst_pops", 32'(n_pops), 32'd4);
    check("burst_done_cnt", 32'(n_done), 32'd4);
    check("burst_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd101);
    check("burst_gap2", 32'(pop_cyc[3] - pop_cyc[2]), 32'd101);

    // Reset during data bit 3 of 0x5A, with 0x81 queued while in reset.
    push(8'h5A);
    wait_pops("rst5a_pop", 5, 20);
    step(45);
    rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    push(8'h81);
    check("midrst_fifo_nonempty", 32'(fifo_empty), 32'd0);
    check("midrst_no_pop", 32'(fifo_pop), 32'd0);
    step(1);
    rst = 1'b0;
    wait_pops("post_rst_pop", 6, 20);
    wait_done("post_rst_done", 5, 200);
    step(3);
    check("post_rst_done_cnt", 32'(n_done), 32'd5);

    // Inputs disturbed mid-frame must not affect the 0x12 frame.
    push(8'h12);
    wait_pops("dist_pop", 7, 20);
    step(30);
    ovr_data  = 8'hEE;
    ovr_empty = 1'b0;
    ovr_en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(2);
      ovr_empty = ~ovr_empty;
    end
    step(5);
    ovr_en = 1'b0;
    wait_done("dist_done", 6, 200);
    step(3);
    check("dist_no_extra_pop", 32'(n_pops), 32'd7);

    // Push while busy: second pop lands in the first frame's tx_done cycle.
    push(8'h11);
    wait_pops("busy_pop1", 8, 20);
    step(50);
    push(8'h22);
    wait_pops("busy_pop2", 9, 200);
    wait_done("busy_done", 8, 300);
    step(3);
    check("busy_gap", 32'(pop_cyc[8] - pop_cyc[7]), 32'd101);
    check("busy_pops", 32'(n_pops), 32'd9);

    check("all_bytes_consumed", 32'(rd_idx), 32'(exp_q.size()));
    check("total_done", 32'(n_done), 32'd8);
    check("idle_line_final", 32'(idle_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

FIFO-draining UART transmitter: the read-side consumer of the team's pointer-based FIFO control unit. It watches the FIFO's `empty` flag and issues single-cycle `pop` requests. For each pop it captures the head-of-FIFO byte and serializes it as an 8N1 UART frame on `tx`. It sits between the PL FIFO (fed by game/motion logic) and the board UART pin.

## Interface
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer truncation), DIV ≥ 2 required, elaboration error otherwise.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, registered by the FIFO.
- fifo_rdata  input  8  FIFO head data mem[r_ptr]; valid combinationally whenever fifo_empty=0.
- fifo_pop  output  1  one-cycle read request to the FIFO; r_ptr advances on the following edge.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is in progress (state ≠ IDLE).
- tx_done  output  1  one-cycle pulse after each stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - fifo_pop = (state==IDLE) && !fifo_empty (combinational).
  - On an edge with fifo_pop=1: latch fifo_rdata into an 8-bit shift register, clear the baud counter and bit counter, go to START.
- START: tx=0 for DIV cycles, then go to DATA.
- DATA:
  - tx = shift[0], LSB first.
  - Each bit is held DIV cycles, then shift right and increment the bit counter (3 bits, 0..7).
  - After bit 7 completes, go to STOP.
- STOP: tx=1 for DIV cycles, then go to IDLE and register tx_done=1 for exactly one cycle.
- Baud counter counts 0..DIV-1; width $clog2(DIV); wraps to 0 on each bit boundary and is held at 0 in IDLE.
- fifo_empty and fifo_rdata are sampled only in IDLE. Changes mid-frame have no effect.
- fifo_pop is never asserted while fifo_empty=1, outside IDLE, or more than once per frame.
- Reset, including mid-frame:
  - State forced to IDLE; tx=1, tx_busy=0, tx_done=0, fifo_pop=0.
  - Counters and shift register cleared.
  - The in-flight byte is dropped (already popped; it is not re-read).

## Timing
- Reset values: tx=1, fifo_pop=0, tx_busy=0, tx_done=0.
- Let E0 be the edge at which fifo_pop=1 is sampled.
- tx falls and tx_busy rises immediately after E0.
- Start bit occupies E0..E0+DIV.
- Data bit k occupies E0+(k+1)·DIV..E0+(k+2)·DIV.
- Stop bit occupies E0+9·DIV..E0+10·DIV.
- After E0+10·DIV: state=IDLE, tx_busy=0, tx_done=1 for one cycle.
- fifo_pop may assert in that same tx_done cycle. Back-to-back frame period is therefore 10·DIV+1 cycles, with a 1-cycle idle-high gap.
- Latency from fifo_empty falling (while IDLE) to fifo_pop: 0 cycles (combinational). First tx transition follows 1 cycle later.
- fifo_rdata must be valid in the pop cycle. This holds for the team's FIFO, whose head-of-FIFO read is combinational.

## Test plan
All scenarios use CLK_FREQ=1000, BAUD=100 (DIV=10) and a behavioural 16-deep FIFO model driven by the DUT's fifo_pop.
- Reset, fifo_empty=1 → tx=1, fifo_pop=0, tx_busy=0, tx_done=0. Hold 500 cycles empty → no pop, tx constantly 1.
- Push 0xA5 → exactly one fifo_pop. tx over 10-cycle bit slots reads 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at E0+100. FIFO returns empty.
- Push 0x00, 0xFF, 0x3C together → 3 pops spaced 101 cycles apart. Decoded bytes match in order. Exactly 3 tx_done pulses; tx_busy low for exactly 1 cycle between frames.
- Assert rst for 2 cycles during data bit 3 of 0x5A → tx=1 and tx_busy=0 immediately. After release with a queued 0x81 → a new pop, and a clean frame 0x81 decodes.
- After pop of 0x12, change fifo_rdata to 0xEE and toggle fifo_empty mid-frame → the transmitted byte is still 0x12, and no extra pop occurs before tx_done.
- Push while busy (0x11 in flight, push 0x22 at cycle 50) → the second pop occurs only in the tx_done cycle of the first frame. Both bytes are received.
